// File: rtl/morse_symbol_accumulator.sv
// Morse symbol accumulator: shifts dot/dash symbols of one letter into a
// WIDTH-bit register, counts them and hands finished letters to a one-entry
// holding stage drained through a valid/ready handshake.
module morse_symbol_accumulator #(
   parameter int WIDTH = 5,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             SI,
   input  logic             commit,
   input  logic             clear,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] code,
   output logic [CNT_W-1:0] len,
   output logic             ovf,
   output logic             out_valid,
   output logic             commit_err
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);

   // live letter state
   logic [WIDTH-1:0] q_q, q_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_live_q, ovf_live_d;
   // holding stage
   logic [WIDTH-1:0] code_q, code_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic             ovf_q, ovf_d;
   logic             out_valid_q, out_valid_d;
   logic             commit_err_q, commit_err_d;

   // live register after a same-cycle symbol has been applied
   logic             shift_ok;
   logic [WIDTH-1:0] q_eff;
   logic [CNT_W-1:0] count_eff;
   logic             ovf_live_eff;
   logic             slot_free;

   // Effective live values: a symbol arriving with commit belongs to that letter
   always_comb begin
      shift_ok     = en && (count_q != FULL_CNT);
      q_eff        = shift_ok ? {q_q[WIDTH-2:0], SI} : q_q;
      count_eff    = shift_ok ? count_q + CNT_W'(1) : count_q;
      ovf_live_eff = ovf_live_q | (en & ~shift_ok);
      slot_free    = ~out_valid_q | out_ready;
   end

   // Next-state selection with priority clear > commit > en
   always_comb begin
      q_d          = q_eff;
      count_d      = count_eff;
      ovf_live_d   = ovf_live_eff;
      code_d       = code_q;
      len_d        = len_q;
      ovf_d        = ovf_q;
      out_valid_d  = out_valid_q & ~out_ready;
      commit_err_d = 1'b0;
      if (clear) begin
         // clear only touches the live letter; the handshake carries on
         q_d        = '0;
         count_d    = '0;
         ovf_live_d = 1'b0;
      end else if (commit && (count_eff != '0)) begin
         if (slot_free) begin
            code_d      = q_eff;
            len_d       = count_eff;
            ovf_d       = ovf_live_eff;
            out_valid_d = 1'b1;
            q_d         = '0;
            count_d     = '0;
            ovf_live_d  = 1'b0;
         end else begin
            // refused: keep accumulating, flag the producer for one cycle
            commit_err_d = 1'b1;
         end
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         q_q          <= '0;
         count_q      <= '0;
         ovf_live_q   <= 1'b0;
         code_q       <= '0;
         len_q        <= '0;
         ovf_q        <= 1'b0;
         out_valid_q  <= 1'b0;
         commit_err_q <= 1'b0;
      end else begin
         q_q          <= q_d;
         count_q      <= count_d;
         ovf_live_q   <= ovf_live_d;
         code_q       <= code_d;
         len_q        <= len_d;
         ovf_q        <= ovf_d;
         out_valid_q  <= out_valid_d;
         commit_err_q <= commit_err_d;
      end
   end

   assign out        = q_q;
   assign count      = count_q;
   assign code       = code_q;
   assign len        = len_q;
   assign ovf        = ovf_q;
   assign out_valid  = out_valid_q;
   assign commit_err = commit_err_q;

endmodule

// File: tb/tb_morse_symbol_accumulator.sv
// Bench for morse_symbol_accumulator: WIDTH=5 and WIDTH=8 instances, letters
// expected by the bench are queued on commit and compared at each transfer.
module tb_morse_symbol_accumulator;

   logic clk;
   int   n_checks = 0;
   int   n_fail   = 0;

   // WIDTH=5 instance
   logic       rst5, en5, si5, cm5, clr5, rdy5;
   logic [4:0] out5, code5;
   logic [2:0] count5, len5;
   logic       ovf5, ov5, ce5;
   // WIDTH=8 instance
   logic       rst8, en8, si8, cm8, clr8, rdy8;
   logic [7:0] out8, code8;
   logic [3:0] count8, len8;
   logic       ovf8, ov8, ce8;

   // expected letters: [7:0] code, [11:8] len, [12] ovf
   logic [15:0] exp5[$];
   logic [15:0] exp8[$];
   logic [15:0] e5, e8;

   morse_symbol_accumulator #(.WIDTH(5)) dut5 (
      .clk(clk), .reset(rst5), .en(en5), .SI(si5), .commit(cm5), .clear(clr5),
      .out_ready(rdy5), .out(out5), .count(count5), .code(code5), .len(len5),
      .ovf(ovf5), .out_valid(ov5), .commit_err(ce5));

   morse_symbol_accumulator #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(rst8), .en(en8), .SI(si8), .commit(cm8), .clear(clr8),
      .out_ready(rdy8), .out(out8), .count(count8), .code(code8), .len(len8),
      .ovf(ovf8), .out_valid(ov8), .commit_err(ce8));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // transfer monitors: inputs are stable at the falling edge
   always @(negedge clk) begin
      if (!rst5 && ov5 && rdy5) begin
         if (exp5.size() == 0) check("sb5_depth", exp5.size(), 1);
         else begin
            e5 = exp5.pop_front();
            check("sb5_code", code5, e5[7:0]);
            check("sb5_len", len5, e5[11:8]);
            check("sb5_ovf", ovf5, e5[12]);
            $display("xfer W5 code=%b len=%0d ovf=%0d", code5, len5, ovf5);
         end
      end
      if (!rst8 && ov8 && rdy8) begin
         if (exp8.size() == 0) check("sb8_depth", exp8.size(), 1);
         else begin
            e8 = exp8.pop_front();
            check("sb8_code", code8, e8[7:0]);
            check("sb8_len", len8, e8[11:8]);
            check("sb8_ovf", ovf8, e8[12]);
            $display("xfer W8 code=%b len=%0d ovf=%0d", code8, len8, ovf8);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sym(input bit w8, input bit s);
      if (w8) begin en8 = 1'b1; si8 = s; end
      else begin en5 = 1'b1; si5 = s; end
      tick();
      en5 = 1'b0; en8 = 1'b0;
   endtask

   task automatic do_commit(input bit w8);
      if (w8) cm8 = 1'b1; else cm5 = 1'b1;
      tick();
      cm5 = 1'b0; cm8 = 1'b0;
   endtask

   task automatic drain(input bit w8);
      if (w8) rdy8 = 1'b1; else rdy5 = 1'b1;
      tick();
      rdy5 = 1'b0; rdy8 = 1'b0;
   endtask

   task automatic push(input bit w8, input logic [7:0] c, input logic [3:0] l, input logic o);
      if (w8) exp8.push_back({3'b000, o, l, c});
      else exp5.push_back({3'b000, o, l, c});
   endtask

   initial begin
      {rst5, en5, si5, cm5, clr5, rdy5} = 6'b100000;
      {rst8, en8, si8, cm8, clr8, rdy8} = 6'b100000;
      tick(); tick();
      rst5 = 1'b0; rst8 = 1'b0;
      check("rst_out", out5, 0);
      check("rst_count", count5, 0);
      check("rst_code", code5, 0);
      check("rst_len", len5, 0);
      check("rst_ovf", ovf5, 0);
      check("rst_valid", ov5, 0);
      check("rst_err", ce5, 0);

      // letter K: dash dot dash
      sym(0, 1); sym(0, 0); sym(0, 1);
      check("k_live", out5, 5'b00101);
      check("k_count", count5, 3);
      push(0, 8'b00101, 3, 0);
      do_commit(0);
      check("k_valid", ov5, 1);
      check("k_code", code5, 5'b00101);
      check("k_len", len5, 3);
      check("k_ovf", ovf5, 0);
      check("k_out0", out5, 0);
      check("k_cnt0", count5, 0);
      drain(0);
      check("k_drained", ov5, 0);

      // letter A with the dash arriving alongside commit
      sym(0, 0);
      en5 = 1'b1; si5 = 1'b1; cm5 = 1'b1;
      push(0, 8'b00001, 2, 0);
      tick();
      en5 = 1'b0; cm5 = 1'b0;
      check("a_valid", ov5, 1);
      check("a_code", code5, 5'b00001);
      check("a_len", len5, 2);
      check("a_err", ce5, 0);
      drain(0);

      // overflow: seven symbols, first five kept
      sym(0, 1); sym(0, 1); sym(0, 1); sym(0, 1); sym(0, 1); sym(0, 0); sym(0, 0);
      check("ovf_count", count5, 5);
      check("ovf_live", out5, 5'b11111);
      push(0, 8'b11111, 5, 1);
      do_commit(0);
      check("ovf_code", code5, 5'b11111);
      check("ovf_len", len5, 5);
      check("ovf_flag", ovf5, 1);
      drain(0);
      sym(0, 0);
      push(0, 8'b00000, 1, 0);
      do_commit(0);
      check("e_ovf", ovf5, 0);
      check("e_len", len5, 1);
      drain(0);

      // back-pressure: T held, E refused
      sym(0, 1);
      push(0, 8'b00001, 1, 0);
      do_commit(0);
      sym(0, 0);
      do_commit(0);
      check("bp_err", ce5, 1);
      check("bp_code", code5, 5'b00001);
      check("bp_len", len5, 1);
      check("bp_count", count5, 1);
      check("bp_valid", ov5, 1);
      tick();
      check("bp_err_pulse", ce5, 0);
      check("bp_hold", code5, 5'b00001);
      drain(0);
      check("bp_drained", ov5, 0);
      check("bp_kept", count5, 1);
      push(0, 8'b00000, 1, 0);
      do_commit(0);
      check("bp_recommit_v", ov5, 1);
      check("bp_recommit_c", code5, 5'b00000);
      check("bp_recommit_l", len5, 1);

      // back-to-back: transfer E and load N in one cycle
      sym(0, 1); sym(0, 0);
      push(0, 8'b00010, 2, 0);
      cm5 = 1'b1; rdy5 = 1'b1;
      tick();
      cm5 = 1'b0; rdy5 = 1'b0;
      check("b2b_valid", ov5, 1);
      check("b2b_code", code5, 5'b00010);
      check("b2b_len", len5, 2);
      check("b2b_err", ce5, 0);
      drain(0);

      // clear beats commit and en
      sym(0, 1); sym(0, 1);
      clr5 = 1'b1; cm5 = 1'b1; en5 = 1'b1; si5 = 1'b1;
      tick();
      {clr5, cm5, en5} = 3'b000;
      check("clr_count", count5, 0);
      check("clr_out", out5, 0);
      check("clr_valid", ov5, 0);
      check("clr_err", ce5, 0);

      // reset during a pending transfer drops the letter
      sym(0, 1);
      do_commit(0);
      check("rr_valid_before", ov5, 1);
      rst5 = 1'b1; rdy5 = 1'b1;
      tick();
      rst5 = 1'b0; rdy5 = 1'b0;
      check("rr_valid", ov5, 0);
      check("rr_code", code5, 0);
      check("rr_len", len5, 0);
      check("rr_count", count5, 0);
      check("rr_out", out5, 0);

      // WIDTH=8: nine symbols, eight kept
      sym(1, 1); sym(1, 0); sym(1, 1); sym(1, 1); sym(1, 0);
      sym(1, 0); sym(1, 1); sym(1, 0); sym(1, 1);
      check("w8_count", count8, 8);
      check("w8_live", out8, 8'hB2);
      push(1, 8'hB2, 8, 1);
      do_commit(1);
      check("w8_len", len8, 8);
      check("w8_ovf", ovf8, 1);
      check("w8_code", code8, 8'hB2);
      drain(1);
      sym(1, 1);
      push(1, 8'h01, 1, 0);
      do_commit(1);
      check("w8_e_ovf", ovf8, 0);
      check("w8_e_len", len8, 1);
      drain(1);
      check("w8_drained", ov8, 0);

      tick();
      check("sb5_left", exp5.size(), 0);
      check("sb8_left", exp8.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/morse_symbol_accumulator.md
# morse_symbol_accumulator

Parametrised successor to the 5-bit symbol shift register. The block collects the dot/dash symbols of one Morse letter into a WIDTH-bit shift register and counts them. On an end-of-letter strobe it captures the code, length and overflow status into an output holding stage. The holding stage is drained by the decoder through a valid/ready handshake. It sits between the key-timing front end, which produces `en`/`SI`/`commit`, and the letter lookup stage.

## Interface
- WIDTH, 5, maximum symbols per letter; must be ≥2. CNT_W = $clog2(WIDTH+1) is derived locally and is not overridable.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state on the clock edge where it is sampled high.
- en  in  1  symbol strobe; SI is shifted in when high.
- SI  in  1  symbol value: 0 = dot, 1 = dash.
- commit  in  1  end-of-letter strobe.
- clear  in  1  discards the letter currently being accumulated.
- out_ready  in  1  consumer accepts the held letter.
- out  out  WIDTH  live shift register contents.
- count  out  CNT_W  number of symbols currently in the live register (0..WIDTH).
- code  out  WIDTH  held letter code.
- len  out  CNT_W  held letter length.
- ovf  out  1  held letter exceeded WIDTH symbols.
- out_valid  out  1  holding stage occupied.
- commit_err  out  1  one-cycle pulse: a commit was refused because the holding stage was busy.

## Operation
- **Live register shift**, when en=1 and count<WIDTH:
  - Q[0] <= SI, Q[i] <= Q[i-1].
  - count <= count+1.
- **Full register:** when en=1 and count==WIDTH, Q and count are unchanged and the internal sticky flag ovf_live is set to 1. The first WIDTH symbols are kept; later symbols are dropped.
- **Code format:** right-justified. The last symbol is at bit 0 and the first symbol is at bit len-1. Bits at or above len are always 0, because the register is zero after every clear, commit or reset.
- **Slot free:** the slot is free when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle.
- **Commit with count_eff>0 and slot free:**
  - code <= Q_eff, len <= count_eff, ovf <= ovf_live_eff, out_valid <= 1.
  - Q, count and ovf_live are cleared.
  - Q_eff, count_eff and ovf_live_eff are the values after any simultaneous en in the same cycle is applied. That symbol therefore belongs to the committed letter.
- **Commit with count_eff==0 (empty letter):** ignored. No output and no error.
- **Commit with count_eff>0 and slot not free:**
  - commit_err pulses for one cycle.
  - The live register keeps accumulating, including any same-cycle en.
  - The held outputs are unchanged.
- **Handshake:**
  - out_valid && out_ready at an edge transfers the letter; out_valid falls next cycle unless a new commit loads the slot in the same cycle (back-to-back, no bubble).
  - code/len/ovf are stable while out_valid=1 and out_ready=0.
- **Priority:** reset > clear > commit > en.
  - clear zeroes Q, count and ovf_live. A same-cycle en or commit is discarded, with no commit_err.
  - clear does not affect the holding stage or the handshake.

## Timing
- Reset values: out=0, count=0, code=0, len=0, ovf=0, out_valid=0, commit_err=0; ovf_live=0.
- Reset asserted mid-letter or while out_valid=1 drops everything on that edge. No transfer occurs, even if out_ready=1.
- en at edge n: out and count are updated at n+1 (1-cycle latency).
- commit at edge n: out_valid, code and len are visible at n+1. The live register reads 0 at n+1.
- commit_err is asserted in cycle n+1 for a refused commit at edge n, for exactly one cycle.
- out_valid has no combinational path from out_ready. All outputs are registered.
- en may be high on consecutive cycles; there is one symbol per cycle maximum.

## Test plan
- **Reset then letter "K":** reset, then en with SI=1,0,1, then commit → next cycle out_valid=1, code=5'b00101, len=3, ovf=0; out=0, count=0.
- **Same-cycle en+commit:** en with SI=0 (dot), then en with SI=1 plus commit in the same cycle ("A") → code=5'b00001, len=2; no commit_err.
- **Overflow:** seven en strobes with SI=1,1,1,1,1,0,0, then commit → code=5'b11111, len=5, ovf=1. Next letter "E" (one dot) → ovf=0.
- **Back-pressure:**
  - Hold out_ready=0 with "T" held, then commit "E" → commit_err pulses once, code still 5'b00001 len 1, count stays 1.
  - Raise out_ready → transfer.
  - Re-commit → "E" is held.
- **Back-to-back:** out_valid=1 and out_ready=1 in the same cycle as a valid commit → out_valid stays 1 and code/len switch to the new letter with no gap.
- **Clear/reset races:**
  - clear+commit+en in one cycle with count=2 → count=0, no output, no commit_err.
  - reset while out_valid=1 and out_ready=1 → all outputs 0 next cycle.
- **Parametric:** run the same tests with WIDTH=8 (count and len are 4 bits wide). Nine symbols give len=8 and ovf=1.
